// File: rtl/filters_pkg.sv
// filters_pkg: shared width derivation, pipeline-depth bounds and saturation limits
// for the filter multiply-accumulate blocks.
package filters_pkg;
    localparam int MIN_STAGE = 2;
    localparam int MAX_STAGE = 6;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/filters_mac_round_sat.sv
// filters_mac_round_sat: round-half-up arithmetic shift of the accumulator, then
// clamp (or truncate) to the signed output width.
module filters_mac_round_sat
    import filters_pkg::*;
#(
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 32,
    parameter int SHIFT      = 0,
    parameter int SAT_EN     = 1
)(
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DOUT_WIDTH-1:0] res,
    output logic                  sat
);
    localparam int W  = ACC_WIDTH + 1 > DOUT_WIDTH ? ACC_WIDTH + 1 : DOUT_WIDTH;
    localparam int RS = SHIFT > 0 ? SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(SHIFT > 0 ? 64'd1 << RS : 64'd0);
    localparam logic signed [W-1:0] MAXV = W'(sat_max(DOUT_WIDTH));
    localparam logic signed [W-1:0] MINV = W'(sat_min(DOUT_WIDTH));

    logic signed [ACC_WIDTH:0] t;
    logic signed [W-1:0]       s;
    logic                      hi, lo;

    // one extra bit so the rounding add cannot overflow
    always_comb begin
        t   = $signed({acc[ACC_WIDTH-1], acc}) + RND;
        s   = W'(t >>> SHIFT);
        hi  = SAT_EN != 0 && s > MAXV;
        lo  = SAT_EN != 0 && s < MINV;
        sat = hi || lo;
        res = hi ? MAXV[DOUT_WIDTH-1:0] : lo ? MINV[DOUT_WIDTH-1:0] : s[DOUT_WIDTH-1:0];
    end
endmodule

// File: rtl/filters_mac_pipe.sv
// filters_mac_pipe: pipelined signed x unsigned multiply-accumulate with framed sums,
// configurable latency, rounding shift and sticky saturation flag.
module filters_mac_pipe
    import filters_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 32,
    parameter int SHIFT      = 0,
    parameter int NUM_STAGE  = 3,
    parameter int SAT_EN     = 1
)(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  acc_clr,
    input  logic                  acc_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  ovf_clr,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int NS = NUM_STAGE < MIN_STAGE ? MIN_STAGE : NUM_STAGE > MAX_STAGE ? MAX_STAGE : NUM_STAGE;

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        pv, pclr, plast, lv;
    logic [ACC_WIDTH:0]          tap;
    logic [DOUT_WIDTH-1:0]       res;
    logic                        sat;

    // stage 1 registers the product, stage 2 folds it into the running sum
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pv    <= 1'b0;
            pclr  <= 1'b0;
            plast <= 1'b0;
            prod  <= '0;
            lv    <= 1'b0;
            acc   <= '0;
        end else if (ce) begin
            pv    <= in_valid;
            pclr  <= acc_clr;
            plast <= acc_last;
            prod  <= PW'($signed(din0)) * PW'($signed({1'b0, din1}));
            lv    <= pv && plast;
            if (pv)
                acc <= pclr ? ACC_WIDTH'(prod) : acc + ACC_WIDTH'(prod);
        end
    end

    generate
        if (NS > 2) begin : g_dly
            logic [NS-3:0][ACC_WIDTH:0] d;
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n)
                    d <= '0;
                else if (ce) begin
                    d[0] <= {lv, acc};
                    for (int i = 1; i < NS - 2; i++)
                        d[i] <= d[i-1];
                end
            end
            assign tap = d[NS-3];
        end else begin : g_nodly
            assign tap = {lv, acc};
        end
    endgenerate

    filters_mac_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .SHIFT     (SHIFT),
        .SAT_EN    (SAT_EN)
    ) u_round_sat (
        .acc(tap[ACC_WIDTH-1:0]),
        .res(res),
        .sat(sat)
    );

    // ovf_clr acts even while the pipeline is frozen; a coincident set wins
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else begin
            ovf <= (ovf && !ovf_clr) || (ce && tap[ACC_WIDTH] && sat);
            if (ce) begin
                out_valid <= tap[ACC_WIDTH];
                if (tap[ACC_WIDTH])
                    dout <= res;
            end
        end
    end
endmodule

// File: tb/tb_filters_mac_pipe.sv
// tb_filters_mac_pipe: directed and random stimulus on two configurations, checked
// against a sum/queue reference model with enabled-cycle latency bookkeeping.
module tb_filters_mac_pipe;
    logic clk = 0, rst_n = 0, ce = 0, in_valid = 0, acc_clr = 0, acc_last = 0, ovf_clr = 0;
    logic [15:0] din0 = '0, din1 = '0;
    logic va, vb, ova_o, ovb_o;
    logic [31:0] da, db;

    localparam longint MAXD = 64'sd2147483647;
    localparam longint MIND = -64'sd2147483648;

    typedef struct {longint val; bit sat; longint due;} res_t;
    res_t qa[$], qb[$];
    int n_chk = 0, n_err = 0;
    longint ecnt = 0, cc = 0, sum = 0, p = 0, exa = 0, exb = 0;
    bit eoa = 0, eob = 0, eva, evb;

    always #5 clk = ~clk;

    filters_mac_pipe dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .acc_last(acc_last), .din0(din0), .din1(din1), .ovf_clr(ovf_clr),
        .out_valid(va), .dout(da), .ovf(ova_o)
    );

    filters_mac_pipe #(.SHIFT(4), .NUM_STAGE(2)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .acc_last(acc_last), .din0(din0), .din1(din1), .ovf_clr(ovf_clr),
        .out_valid(vb), .dout(db), .ovf(ovb_o)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic res_t conv(input longint s, input int sh, input longint due);
        longint r;
        res_t x;
        r = sh > 0 ? (s + (longint'(1) <<< (sh - 1))) >>> sh : s;
        x.due = due;
        x.sat = r > MAXD || r < MIND;
        x.val = r > MAXD ? MAXD : r < MIND ? MIND : r;
        return x;
    endfunction

    always @(posedge clk) begin
        cc++;
        if (rst_n) begin
            if (ovf_clr) begin
                eoa = 0;
                eob = 0;
            end
            if (ce) begin
                ecnt++;
                if (qa.size() > 0 && qa[0].due < ecnt) void'(qa.pop_front());
                if (qb.size() > 0 && qb[0].due < ecnt) void'(qb.pop_front());
                if (qa.size() > 0 && qa[0].due == ecnt) begin
                    exa = qa[0].val;
                    eoa |= qa[0].sat;
                end
                if (qb.size() > 0 && qb[0].due == ecnt) begin
                    exb = qb[0].val;
                    eob |= qb[0].sat;
                end
                if (in_valid) begin
                    p = longint'($signed(din0)) * longint'(din1);
                    sum = acc_clr ? p : sum + p;
                    sum = (sum <<< 24) >>> 24;
                    if (acc_last) begin
                        qa.push_back(conv(sum, 0, ecnt + 3));
                        qb.push_back(conv(sum, 4, ecnt + 2));
                    end
                end
            end
        end
    end

    always @(negedge rst_n) begin
        qa.delete();
        qb.delete();
        sum = 0;
        exa = 0;
        exb = 0;
        eoa = 0;
        eob = 0;
    end

    always @(negedge clk) begin
        eva = qa.size() > 0 && qa[0].due == ecnt;
        evb = qb.size() > 0 && qb[0].due == ecnt;
        chk("a_valid", va, eva);
        chk("a_dout", longint'($signed(da)), exa);
        chk("a_ovf", ova_o, eoa);
        chk("b_valid", vb, evb);
        chk("b_dout", longint'($signed(db)), exb);
        chk("b_ovf", ovb_o, eob);
    end

    task automatic cyc(input bit c, v, cl, la, input int d0, d1, input bit oc = 0);
        ce = c;
        in_valid = v;
        acc_clr = cl;
        acc_last = la;
        din0 = 16'(d0);
        din1 = 16'(d1);
        ovf_clr = oc;
        @(negedge clk);
    endtask

    task automatic wait_out(input string tag, input longint exp, output int n);
        ce = 1;
        in_valid = 0;
        acc_clr = 0;
        acc_last = 0;
        ovf_clr = 0;
        n = 0;
        while (!va && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, va, 1);
        chk(tag, longint'($signed(da)), exp);
    endtask

    initial begin
        int n;
        longint c0;
        repeat (2) @(negedge clk);
        chk("rst_valid", va, 0);
        chk("rst_dout", da, 0);
        chk("rst_ovf", ova_o, 0);
        rst_n = 1;

        cyc(1, 1, 1, 1, -3, 65535);
        wait_out("single", -196605, n);
        chk("lat3", n, 3);
        chk("single_ovf", ova_o, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("one_cycle", va, 0);

        c0 = cc;
        cyc(1, 1, 1, 0, 1000, 2000);
        cyc(1, 1, 0, 0, 1000, 2000);
        cyc(1, 1, 0, 0, 1000, 2000);
        cyc(1, 1, 0, 1, 1000, 2000);
        wait_out("sum4", 8000000, n);
        chk("sum4_cycles", cc - c0, 7);

        c0 = cc;
        cyc(1, 1, 1, 0, 1000, 2000);
        cyc(1, 1, 0, 0, 1000, 2000);
        repeat (5) cyc(0, 1, 0, 1, 7, 7);
        cyc(1, 1, 0, 0, 1000, 2000);
        cyc(1, 1, 0, 1, 1000, 2000);
        wait_out("stall", 8000000, n);
        chk("stall_cycles", cc - c0, 12);

        cyc(1, 1, 1, 0, 32767, 65535);
        cyc(1, 1, 0, 1, 32767, 65535);
        wait_out("sat_hi", MAXD, n);
        chk("ovf_set", ova_o, 1);
        cyc(1, 1, 1, 0, -32768, 65535);
        cyc(1, 1, 0, 1, -32768, 65535);
        wait_out("sat_lo", MIND, n);
        chk("ovf_hold", ova_o, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("ovf_clr", ova_o, 0);

        cyc(1, 1, 1, 0, 32767, 65535);
        cyc(1, 1, 0, 1, 32767, 65535);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 1);
        chk("set_clr", ova_o, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);

        cyc(1, 1, 1, 1, 24, 1);
        wait_out("p24", 24, n);
        chk("shift_pos", longint'($signed(db)), 2);
        cyc(1, 1, 1, 1, -24, 1);
        wait_out("n24", -24, n);
        chk("shift_neg", longint'($signed(db)), -1);

        cyc(1, 1, 1, 0, 3, 4);
        cyc(1, 1, 0, 1, 5, 6);
        cyc(1, 1, 1, 1, -7, 8);
        cyc(1, 1, 1, 0, 100, 100);
        cyc(1, 1, 0, 1, 1, 1);
        repeat (6) cyc(1, 0, 0, 0, 0, 0);

        cyc(1, 1, 1, 1, 9, 9);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1000, 2000);
        cyc(1, 1, 0, 0, 1000, 2000);
        ce = 1;
        in_valid = 1;
        acc_clr = 0;
        acc_last = 0;
        chk("pre_rst_valid", va, 1);
        #2 rst_n = 0;
        #1 chk("rst_async_valid", va, 0);
        chk("rst_async_dout", da, 0);
        @(negedge clk);
        rst_n = 1;
        cyc(1, 1, 0, 0, 5, 7);
        cyc(1, 1, 0, 1, 5, 7);
        wait_out("fresh", 70, n);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(9, 0) != 0, $urandom_range(9, 0) < 7, $urandom_range(3, 0) == 0,
                $urandom_range(3, 0) == 0, $urandom, $urandom, $urandom_range(19, 0) == 0);
        repeat (10) cyc(1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/filters_mac_pipe.md
FILTERS_MAC_PIPE -- requirements
Module: filters_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 16, width of signed operand din0.
REQ-002 SHALL have parameter DIN1_WIDTH, default 16, width of unsigned operand din1.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, accumulator width; legal only if ACC_WIDTH >= DIN0_WIDTH+DIN1_WIDTH.
REQ-004 SHALL have parameter DOUT_WIDTH, default 32, result width.
REQ-005 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-006 SHALL have parameter NUM_STAGE, default 3, input-to-output latency in cycles; legal range 2..6.
REQ-007 SHALL have parameter SAT_EN, default 1; 1 = saturate, 0 = truncate.
REQ-008 SHALL have ports: ap_clk in 1 (clock); ap_rst_n in 1 (reset, active-low, asynchronous).
REQ-009 SHALL have ports: ce in 1 (pipeline enable); in_valid in 1 (sample valid); acc_clr in 1 (sample starts a new sum); acc_last in 1 (sample ends the sum).
REQ-010 SHALL have ports: din0 in DIN0_WIDTH (signed); din1 in DIN1_WIDTH (unsigned); ovf_clr in 1 (clear sticky flag).
REQ-011 SHALL have ports: out_valid out 1 (result valid); dout out DOUT_WIDTH (signed result); ovf out 1 (sticky saturation flag).

Function
REQ-012 Product SHALL be signed din0 times zero-extended din1: signed, DIN0_WIDTH+DIN1_WIDTH bits, exact.
REQ-013 A sample SHALL be accepted only on a rising ap_clk edge with ce=1 and in_valid=1; acc_clr and acc_last SHALL be ignored when in_valid=0.
REQ-014 Accepted sample with acc_clr=1 SHALL load the accumulator with its sign-extended product; otherwise the product SHALL be added to the accumulator.
REQ-015 Accumulator arithmetic SHALL wrap modulo 2^ACC_WIDTH; wrap SHALL not set ovf.
REQ-016 A sample with acc_last=1 SHALL produce exactly one result; out_valid SHALL assert NUM_STAGE enabled cycles after acceptance and last one enabled cycle.
REQ-017 acc_clr=1 and acc_last=1 on the same sample SHALL output that sample's product alone.
REQ-018 ce=0 SHALL freeze all pipeline, accumulator, out_valid and dout registers; latency is counted in ce=1 cycles only.
REQ-019 Output conversion: if SHIFT>0, add 2^(SHIFT-1) (round half up), then arithmetic shift right by SHIFT, at full ACC_WIDTH+1 precision.
REQ-020 If SAT_EN=1, values outside the DOUT_WIDTH signed range SHALL clamp to max/min; if SAT_EN=0, low DOUT_WIDTH bits SHALL be kept.
REQ-021 ovf SHALL set on any output cycle where clamping occurred and hold until ovf_clr=1; simultaneous set and clear SHALL leave ovf=1.
REQ-022 Back-to-back sums (acc_last on sample n, acc_clr on sample n+1) SHALL sustain one sample per cycle with no bubbles.
REQ-023 dout SHALL hold its last value while out_valid=0.

Reset
REQ-024 ap_rst_n=0 SHALL asynchronously clear out_valid, dout, ovf, the accumulator and all pipeline valid flags to 0, including mid-sum; in-flight samples are discarded.
REQ-025 The first sample after reset SHALL accumulate onto 0 when acc_clr=0.

Structure
REQ-026 Shared package filters_pkg SHALL hold the PROD_WIDTH derivation, the legal NUM_STAGE bounds and the saturation-limit constants.
REQ-027 Shift, round and saturate SHALL be one combinational sub-module, filters_mac_round_sat, instantiated before the output register.

Verification (defaults unless stated)
REQ-028 din0=-3, din1=65535, clr=last=1 -> after 3 cycles out_valid=1 for 1 cycle, dout=-196605, ovf=0.
REQ-029 Four samples din0=1000, din1=2000, clr on first, last on fourth -> a single out_valid, dout=8000000.
REQ-030 Two samples din0=32767, din1=65535 -> dout=2147483647, ovf=1; then two samples din0=-32768, din1=65535 -> dout=-2147483648; ovf_clr pulse -> ovf=0.
REQ-031 ce=0 for 5 cycles mid-sum of REQ-029 -> dout=8000000, out_valid delayed exactly 5 cycles.
REQ-032 SHIFT=4: single product 24 -> dout=2; single product -24 -> dout=-1.
REQ-033 ap_rst_n low during the third sample of REQ-029 -> out_valid=0 immediately; a fresh run without clr then yields its own sum only.
